ct_spsram_512x7_acc: RTL and testbench
======================================

# ct_spsram_512x7_acc

Access controller for one 512x7 single-port SRAM, on the initiator side of the macro's active-low CEN/GWEN/WEN port. It clears every entry after reset or on request. It then accepts one read or bit-masked write per cycle over a valid/ready handshake and returns read data with a registered valid one cycle later. LSU tables that need a 512-entry, 7-bit store instantiate it beside the SRAM wrapper.

## Interface
Reset is asynchronous, active-low (`cpurst_b`); one clock (`forever_cpuclk`).

Parameters:
- ADDR_WIDTH, 9, SRAM address width (depth = 2^ADDR_WIDTH)
- DATA_WIDTH, 7, SRAM data / bit-write width
- INIT_VAL, 7'b0, value written to every entry during initialization

Ports:
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  asynchronous active-low reset
- init_req  in  1  single-cycle pulse: re-clear the whole array
- req_vld  in  1  request valid
- req_wen  in  1  1 = write, 0 = read
- req_addr  in  9  request address
- req_wdata  in  7  write data
- req_bwe  in  7  per-bit write enable, active-high
- req_rdy  out  1  request accepted when req_vld & req_rdy
- rd_vld  out  1  read data valid (one-cycle pulse)
- rd_data  out  7  read data, held until the next read returns
- init_done  out  1  array initialized, controller in READY
- sram_a  out  9  SRAM address
- sram_cen  out  1  SRAM chip enable, active-low
- sram_gwen  out  1  SRAM global write enable, active-low
- sram_wen  out  7  SRAM bit write enable, active-low
- sram_d  out  7  SRAM write data
- sram_q  in  7  SRAM read data, valid the cycle after a read access

## Operation
- FSM states: RST_WAIT (reset state), INIT, READY.
- RST_WAIT → INIT after one cycle out of reset. The init counter is 0 on entry.
- INIT: each cycle drives sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_a=counter, sram_d=INIT_VAL, then increments the counter. The counter is ADDR_WIDTH+1 bits wide, so it cannot wrap to 0.
- INIT → READY in the cycle after address 511 is written, so INIT lasts exactly 512 cycles.
- READY: req_rdy=1, init_done=1. init_req → INIT with the counter cleared, starting next cycle.
- init_req is ignored in RST_WAIT and INIT.
- Accepted request: sram_cen=0 and sram_a=req_addr.
  - Write: sram_gwen=0, sram_wen=~req_bwe, sram_d=req_wdata. req_bwe=0 is a legal no-op write.
  - Read: sram_gwen=1, sram_wen=all 1.
- No accepted request and not INIT: sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
- SRAM-side outputs are combinational from the state and the request. The SRAM samples them on the clock edge that ends the cycle.
- rd_data = sram_q while rd_vld=1. Otherwise rd_data is a holding register, loaded from sram_q on every rd_vld cycle.
- Request and init_req in the same READY cycle: the request is accepted and performed, and INIT starts next cycle. A read's rd_vld still fires in the first INIT cycle.
- Reset asserted mid-INIT or mid-read: everything returns to reset values. The sweep restarts from address 0, and a pending rd_vld is dropped.

## Timing
- Reset values: req_rdy=0, init_done=0, rd_vld=0, rd_data=0, sram_cen=1, sram_gwen=1, sram_wen=7'h7f, sram_a=0, sram_d=0. State is RST_WAIT and the counter is 0.
- Reset deassert at edge E0: INIT runs cycles 1..512 and READY (req_rdy=1) starts at cycle 513.
- Read latency: accepted in cycle N → rd_vld=1 with data in cycle N+1. Back-to-back reads give one rd_vld per cycle.
- Write then read of the same address in consecutive cycles returns the new data. The SRAM is single-port and in-order, so no forwarding is needed.
- Throughput is one request per cycle in READY. req_rdy is 0 for all of RST_WAIT and INIT.

## Test plan
- Reset release, no traffic → sram_cen low for exactly 512 consecutive cycles with sram_a 0..511 and sram_d=0; init_done rises at cycle 513; reading addr 0x1ff returns 7'h00.
- Write addr 0x05 data 7'h55 bwe 7'h7f, then write addr 0x05 data 7'h2a bwe 7'h0f, then read → rd_vld next cycle, rd_data=7'h5a; sram_wen=7'h70 on the second write.
- Reads of 0x010, 0x011, 0x012 issued back-to-back after writing 7'h01, 7'h02, 7'h03 → rd_vld high for 3 cycles with 7'h01, 7'h02, 7'h03; rd_data then holds 7'h03 while idle.
- init_req with a read of a written address (7'h33) in the same cycle → rd_data=7'h33 in the next cycle; req_rdy=0 for 512 cycles; a later read returns 7'h00.
- cpurst_b asserted at init counter 200 → all outputs at reset values immediately; after release the sweep restarts at sram_a=0 and lasts the full 512 cycles.
- req_vld held during INIT → no SRAM write from the request and no rd_vld; the request is accepted in the first READY cycle.

Source files
------------

// File: rtl/ct_spsram_512x7_acc.sv
// ct_spsram_512x7_acc: access controller for a 512x7 single-port SRAM (active-low CEN/GWEN/WEN).
// Clears every entry after reset or on init_req, then serves one read or bit-masked write per cycle.
// Ports: forever_cpuclk/cpurst_b clock and async active-low reset; init_req re-clear pulse;
// req_* request channel (valid/ready, wen, addr, wdata, per-bit bwe); rd_vld/rd_data read return;
// init_done array cleared; sram_a/cen/gwen/wen/d drive the macro, sram_q is its read data.
module ct_spsram_512x7_acc #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 7,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  init_req,
  input  logic                  req_vld,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [DATA_WIDTH-1:0] req_bwe,
  output logic                  req_rdy,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);
  typedef enum logic [1:0] {RST_WAIT, INIT, READY} state_t;
  localparam logic [ADDR_WIDTH:0] LAST = {1'b0, {ADDR_WIDTH{1'b1}}};
  state_t state;
  // One bit wider than the address so the sweep never wraps back to 0.
  logic [ADDR_WIDTH:0] cnt;
  logic [DATA_WIDTH-1:0] rd_hold;
  logic init, acc, wr;
  assign init      = state == INIT;
  assign req_rdy   = state == READY;
  assign init_done = state == READY;
  assign acc       = req_vld & req_rdy;
  assign wr        = acc & req_wen;
  assign sram_cen  = ~(init | acc);
  assign sram_gwen = ~(init | wr);
  assign sram_wen  = init ? '0 : wr ? ~req_bwe : '1;
  assign sram_a    = init ? cnt[ADDR_WIDTH-1:0] : acc ? req_addr : '0;
  assign sram_d    = init ? INIT_VAL : wr ? req_wdata : '0;
  // The macro's Q is only valid in the cycle after the read; hold it for later cycles.
  assign rd_data   = rd_vld ? sram_q : rd_hold;
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state   <= RST_WAIT;
      cnt     <= '0;
      rd_vld  <= 1'b0;
      rd_hold <= '0;
    end else begin
      rd_vld <= acc & ~req_wen;
      if (rd_vld) rd_hold <= sram_q;
      case (state)
        RST_WAIT: begin
          state <= INIT;
          cnt   <= '0;
        end
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= READY;
        end
        READY: if (init_req) begin
          state <= INIT;
          cnt   <= '0;
        end
        default: state <= RST_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_ct_spsram_512x7_acc.sv
// tb_ct_spsram_512x7_acc: randomized self-checking bench with an SRAM macro model and a reference memory.
module tb_ct_spsram_512x7_acc;
  logic clk = 0, rst_n = 0, init_req = 0, req_vld = 0, req_wen = 0;
  logic [8:0] req_addr = 0;
  logic [6:0] req_wdata = 0, req_bwe = 0;
  logic req_rdy, rd_vld, init_done, sram_cen, sram_gwen;
  logic [6:0] rd_data, sram_wen, sram_d;
  logic [6:0] sram_q = 0;
  logic [8:0] sram_a;
  logic [6:0] macro [512] = '{default: 7'h5b};
  logic [6:0] mem [512];
  bit pend = 0;
  logic [6:0] pend_val = 0, hold = 0;
  int n_cmp = 0, n_err = 0;

  ct_spsram_512x7_acc dut (
    .forever_cpuclk(clk), .cpurst_b(rst_n), .init_req(init_req),
    .req_vld(req_vld), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_bwe(req_bwe), .req_rdy(req_rdy),
    .rd_vld(rd_vld), .rd_data(rd_data), .init_done(init_done),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
    .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!sram_cen) begin
      if (!sram_gwen) macro[sram_a] <= (macro[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else sram_q <= macro[sram_a];
    end

  task automatic chk(string tag, int obs, int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rst();
    chk("rst_rdy", req_rdy, 0);
    chk("rst_done", init_done, 0);
    chk("rst_rdv", rd_vld, 0);
    chk("rst_rdd", rd_data, 0);
    chk("rst_cen", sram_cen, 1);
    chk("rst_gwen", sram_gwen, 1);
    chk("rst_wen", sram_wen, 7'h7f);
    chk("rst_a", sram_a, 0);
    chk("rst_d", sram_d, 0);
    pend = 0;
    hold = 0;
  endtask

  task automatic cyc(bit v, bit w, logic [8:0] a, logic [6:0] d, logic [6:0] be, bit ini);
    logic [6:0] ew, ed, nb;
    req_vld = v; req_wen = w; req_addr = a; req_wdata = d; req_bwe = be; init_req = ini;
    nb = ~be;
    ew = (v && w) ? nb : 7'h7f;
    ed = (v && w) ? d : 7'h00;
    @(negedge clk);
    chk("rdy", req_rdy, 1);
    chk("rd_vld", rd_vld, pend);
    chk("rd_data", rd_data, pend ? pend_val : hold);
    chk("cen", sram_cen, !v);
    chk("a", sram_a, v ? a : 9'd0);
    chk("gwen", sram_gwen, !(v && w));
    chk("wen", sram_wen, ew);
    chk("d", sram_d, ed);
    if (pend) hold = pend_val;
    pend = v && !w;
    if (v && !w) pend_val = mem[a];
    if (v && w) mem[a] = (mem[a] & nb) | (d & be);
    @(posedge clk); #1;
    init_req = 0;
  endtask

  task automatic wait_init(int exp_pre);
    int pre = 0, len = 0, i = 0;
    while (!init_done && i < 1200) begin
      @(negedge clk);
      chk("init_rdy", req_rdy, 0);
      chk("init_rdv", rd_vld, int'(i == 0 && pend));
      if (i == 0 && pend) begin
        chk("init_rdd", rd_data, pend_val);
        hold = pend_val;
      end
      if (!sram_cen) begin
        chk("init_a", sram_a, len);
        chk("init_d", sram_d, 0);
        chk("init_wen", sram_wen, 0);
        chk("init_gwen", sram_gwen, 0);
        len++;
      end else begin
        chk("init_gap", len, 0);
        pre++;
      end
      i++;
      @(posedge clk); #1;
    end
    pend = 0;
    chk("init_done", init_done, 1);
    chk("init_len", len, 512);
    chk("init_pre", pre, exp_pre);
    foreach (mem[k]) mem[k] = 7'h00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    bit found;
    repeat (3) @(posedge clk);
    #1;
    chk_rst();
    rst_n = 1;
    wait_init(1);
    cyc(1, 0, 9'h1ff, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rd_1ff", rd_data, 0);
    cyc(1, 1, 9'h005, 7'h55, 7'h7f, 0);
    cyc(1, 1, 9'h005, 7'h2a, 7'h0f, 0);
    cyc(1, 0, 9'h005, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rd_5a", rd_data, 7'h5a);
    for (int k = 0; k < 3; k++) cyc(1, 1, 9'h010 + 9'(k), 7'(k + 1), 7'h7f, 0);
    for (int k = 0; k < 3; k++) cyc(1, 0, 9'h010 + 9'(k), 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("hold_03", rd_data, 7'h03);
    for (int n = 0; n < 400; n++) begin
      r = $urandom;
      cyc(r[1:0] != 0, r[2], r[3] ? {5'd0, r[7:4]} : r[16:8], r[23:17], r[30:24], 0);
    end
    cyc(1, 1, 9'h020, 7'h33, 7'h7f, 0);
    cyc(1, 0, 9'h020, 0, 0, 1);
    req_vld = 0;
    wait_init(0);
    cyc(1, 0, 9'h020, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rd_after_init", rd_data, 0);
    cyc(1, 1, 9'h030, 7'h44, 7'h7f, 0);
    cyc(1, 0, 9'h030, 0, 0, 0);
    req_vld = 0;
    chk("rdv_before_rst", rd_vld, 1);
    rst_n = 0;
    #1;
    chk_rst();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    found = 0;
    for (int n = 0; n < 1000 && !found; n++) begin
      @(negedge clk);
      found = !sram_cen && sram_a == 9'd200;
    end
    chk("hit_200", found, 1);
    rst_n = 0;
    #1;
    chk_rst();
    @(posedge clk);
    #1;
    rst_n = 1;
    req_vld = 1; req_wen = 1; req_addr = 9'h007; req_wdata = 7'h7f; req_bwe = 7'h7f;
    wait_init(1);
    cyc(1, 1, 9'h007, 7'h7f, 7'h7f, 0);
    cyc(1, 0, 9'h007, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("held_write", rd_data, 7'h7f);
    cyc(0, 0, 0, 0, 0, 1);
    req_vld = 1; req_wen = 0; req_addr = 9'h007;
    wait_init(0);
    cyc(1, 0, 9'h007, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("held_read", rd_data, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
